// File: rtl/seq_pkg.sv
// Shared types and constants for the ALU sequencer and its register file.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Opcode / func encodings
  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [4:0] OP_BRANCH_HI = 5'b00010;   // 6'b00010x
  localparam logic [5:0] OP_LOAD      = 6'b100011;
  localparam logic [5:0] OP_STORE     = 6'b101011;
  localparam logic [2:0] FN_MULDIV_HI = 3'b011;     // func 6'b011xxx

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 3;

  // Stores, branches and mult/div (results kept in ALU hi/lo) do not write a GPR.
  function automatic logic writes_back(input logic [31:0] ir, input logic is_store);
    logic [5:0] op;
    op = ir[OP_MSB:OP_LSB];
    if (is_store || op == OP_STORE)                          return 1'b0;
    if (op[5:1] == OP_BRANCH_HI)                             return 1'b0;
    if (op == OP_RTYPE && ir[FN_MSB:FN_LSB] == FN_MULDIV_HI) return 1'b0;
    return 1'b1;
  endfunction

  // R-type writes rd, everything else writes rt.
  function automatic logic [4:0] wb_dest(input logic [31:0] ir);
    return (ir[OP_MSB:OP_LSB] == OP_RTYPE) ? ir[RD_MSB:RD_LSB] : ir[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 32x32 register file: two async read ports, one sync write port, r0 hard zero.
// Latency: reads combinational; a write is visible on the read ports the cycle after.
// Backpressure: none; writes to r0 are dropped, rst clears every entry synchronously.
// Ports: clk, rst | ra1_i/rd1_o, ra2_i/rd2_o read ports | we_i, wa_i, wd_i write port.
module seq_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  output logic [31:0] rd1_o,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_q[ra2_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/[MEM]/WB controller around an external combinational ALU.
// Latency: 4 cycles ALU/branch, 5 cycles load/store with zero-wait acks; +1 per wait cycle.
// Backpressure: req held (addr/data stable) until ack; acks outside FETCH/MEM are ignored.
// Ports: clk/rst/start/halted control | imem_* fetch handshake | dmem_* data handshake |
//        alu_instr/alu_gr1/alu_gr2 to ALU, alu_c + flags back | retired instruction count.
module alu_sequencer
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        halted,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_gr1,
  output logic [31:0] alu_gr2,
  input  logic [31:0] alu_c,
  input  logic        alu_branch,
  input  logic        alu_load,
  input  logic        alu_store,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, r_q, retired_q;
  logic        branch_q, load_q, store_q;
  logic [31:0] rd1, rd2;
  logic        rf_we;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = (imem_rdata == HALT_WORD) ? S_HALT : S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (alu_load || alu_store) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only; addr/data are zeroed when no request
  always_comb begin
    imem_req   = (state_q == S_FETCH);
    imem_addr  = imem_req ? pc_q : 32'd0;
    dmem_req   = (state_q == S_MEM);
    dmem_we    = dmem_req && store_q;
    dmem_addr  = dmem_req ? r_q : 32'd0;
    dmem_wdata = dmem_req ? b_q : 32'd0;
    halted     = (state_q == S_HALT);
  end

  assign alu_instr = ir_q;
  assign alu_gr1   = a_q;
  assign alu_gr2   = b_q;
  assign retired   = retired_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      branch_q  <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (imem_ack) ir_q <= imem_rdata;
        S_DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXEC: begin
          r_q      <= alu_c;
          branch_q <= alu_branch;
          load_q   <= alu_load;
          store_q  <= alu_store;
        end
        S_MEM: if (dmem_ack && load_q) r_q <= dmem_rdata;
        S_WB: begin
          // Branch offset is a word count; wrap-around is intentional
          pc_q      <= branch_q ? (pc_q + 32'd4 + (r_q << 2)) : (pc_q + 32'd4);
          retired_q <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign rf_we = (state_q == S_WB) && writes_back(ir_q, store_q);

  seq_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (ir_q[RS_MSB:RS_LSB]),
    .rd1_o (rd1),
    .ra2_i (ir_q[RT_MSB:RT_LSB]),
    .rd2_o (rd2),
    .we_i  (rf_we),
    .wa_i  (wb_dest(ir_q)),
    .wd_i  (r_q)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: memory responders with programmable wait, a tiny ALU stub and
// transaction monitors feed immediate assertions in a single linear stimulus block.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halted;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] alu_instr, alu_gr1, alu_gr2, alu_c;
  logic        alu_branch, alu_load, alu_store;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_instr(alu_instr), .alu_gr1(alu_gr1), .alu_gr2(alu_gr2), .alu_c(alu_c),
    .alu_branch(alu_branch), .alu_load(alu_load), .alu_store(alu_store),
    .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Small ALU stub covering the opcodes used by the program
  logic [31:0] sext;
  always_comb begin
    sext       = {{16{alu_instr[15]}}, alu_instr[15:0]};
    alu_c      = 32'd0;
    alu_branch = 1'b0;
    alu_load   = 1'b0;
    alu_store  = 1'b0;
    case (alu_instr[31:26])
      6'b000000: alu_c = alu_gr1 + alu_gr2;                 // add
      6'b001000: alu_c = alu_gr1 + sext;                    // addi
      6'b100011: begin alu_c = alu_gr1 + sext; alu_load  = 1'b1; end
      6'b101011: begin alu_c = alu_gr1 + sext; alu_store = 1'b1; end
      6'b000100: begin alu_c = sext; alu_branch = (alu_gr1 == alu_gr2); end
      default: ;
    endcase
  end

  // Instruction memory responder (drives 1 time unit after the falling edge)
  logic [31:0] imem [64];
  int          imem_wait = 0;
  logic        imem_manual = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  initial begin
    int icnt = 0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (imem_manual) begin
        imem_ack = man_ack; imem_rdata = man_rdata;
      end else if (imem_req) begin
        if (icnt >= imem_wait) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:2]]; icnt = 0;
        end else begin
          imem_ack = 1'b0; icnt++;
        end
      end else begin
        imem_ack = 1'b0; icnt = 0;
      end
    end
  end

  // Data memory responder
  int dmem_wait = 0;
  initial begin
    int dcnt = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (dmem_req && dcnt >= dmem_wait) begin
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; dcnt = 0;
      end else if (dmem_req) begin
        dmem_ack = 1'b0; dcnt++;
      end else begin
        dmem_ack = 1'b0; dcnt = 0;
      end
    end
  end

  // Monitors: fetch start cycle/address, data transaction length/stability/content
  int          fetch_cyc[$];
  logic [31:0] fetch_addr[$];
  int          d_len[$];
  logic        d_stable[$], d_we[$];
  logic [31:0] d_addr[$], d_wdata[$];
  initial begin
    logic        iprev = 1'b0, dprev = 1'b0, stab = 1'b1, we0 = 1'b0;
    int          len = 0;
    logic [31:0] a0 = 32'd0, w0 = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req && !iprev) begin fetch_cyc.push_back(cyc); fetch_addr.push_back(imem_addr); end
      iprev = imem_req;
      if (dmem_req) begin
        if (!dprev) begin len = 1; a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; stab = 1'b1; end
        else begin
          len++;
          if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) stab = 1'b0;
        end
      end else if (dprev) begin
        d_len.push_back(len); d_stable.push_back(stab); d_we.push_back(we0);
        d_addr.push_back(a0); d_wdata.push_back(w0);
      end
      dprev = dmem_req;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_fetches(input string tag, input int cnt, input int budget);
    int n = 0;
    while (fetch_addr.size() < cnt && n < budget) begin @(negedge clk); #2; n++; end
    check(tag, {31'd0, fetch_addr.size() >= cnt}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
    imem[0] = 32'h2001_0005;   // addi r1, r0, 5
    imem[1] = 32'h0021_1020;   // add  r2, r1, r1
    rst = 1'b1; start = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_imem_req",   {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr",  imem_addr, 32'd0);
    check("rst_dmem_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we",    {31'd0, dmem_we}, 32'd0);
    check("rst_dmem_addr",  dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_alu_instr",  alu_instr, 32'd0);
    check("rst_alu_gr1",    alu_gr1, 32'd0);
    check("rst_alu_gr2",    alu_gr2, 32'd0);
    check("rst_halted",     {31'd0, halted}, 32'd0);
    check("rst_retired",    retired, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_fetch",  {31'd0, imem_req}, 32'd0);

    // addi / add / HALT
    pulse_start();
    wait_halted("prog1_halt", 100);
    check("prog1_cycles",   fetch_cyc[2] - fetch_cyc[0], 32'd8);
    check("prog1_halt_pc",  fetch_addr[2], 32'd8);
    check("prog1_r1",       dut.u_rf.mem_q[1], 32'd5);
    check("prog1_r2",       dut.u_rf.mem_q[2], 32'd10);
    check("prog1_pc",       dut.pc_q, 32'd8);
    check("prog1_retired",  retired, 32'd2);
    repeat (3) @(negedge clk);
    check("halt_retired_hold", retired, 32'd2);
    check("halt_pc_hold",   dut.pc_q, 32'd8);

    // Resume at PC 8: lw, sw, beq -1, then (patched) add r0, halt
    imem[2] = 32'h8C23_0040;   // lw  r3, 0x40(r1)
    imem[3] = 32'hAC22_0004;   // sw  r2, 4(r1)
    imem[4] = 32'h1000_FFFF;   // beq r0, r0, -1
    dmem_wait = 3;
    pulse_start();
    wait_fetches("beq_fetched", 6, 100);
    imem[4] = 32'h0021_0020;   // add r0, r1, r1 replaces the branch for its refetch
    wait_halted("prog2_halt", 200);
    check("resume_pc",      fetch_addr[3], 32'd8);
    check("load_cycles",    fetch_cyc[4] - fetch_cyc[3], 32'd8);
    check("load_req_len",   d_len[0], 32'd4);
    check("load_stable",    {31'd0, d_stable[0]}, 32'd1);
    check("load_addr",      d_addr[0], 32'h45);
    check("load_we",        {31'd0, d_we[0]}, 32'd0);
    check("load_r3",        dut.u_rf.mem_q[3], 32'hDEAD_BEEF);
    check("store_we",       {31'd0, d_we[1]}, 32'd1);
    check("store_addr",     d_addr[1], 32'd9);
    check("store_wdata",    d_wdata[1], 32'd10);
    check("store_r2_kept",  dut.u_rf.mem_q[2], 32'd10);
    check("branch_target",  fetch_addr[6], 32'h10);
    check("after_add_r0",   fetch_addr[7], 32'h14);
    check("r0_zero",        dut.u_rf.mem_q[0], 32'd0);
    check("prog2_retired",  retired, 32'd6);
    check("prog2_pc",       dut.pc_q, 32'h14);

    // Reset mid-FETCH, late ack, start coincident with reset
    imem_manual = 1'b1; man_ack = 1'b0;
    pulse_start();
    @(negedge clk);
    check("midfetch_req",   {31'd0, imem_req}, 32'd1);
    check("midfetch_addr",  imem_addr, 32'h14);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    man_ack = 1'b1; man_rdata = 32'h2001_0005;
    check("rst_req_drop",   {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    man_ack = 1'b0;
    check("late_ack_ignored", alu_instr, 32'd0);
    check("post_rst_req",   {31'd0, imem_req}, 32'd0);
    check("post_rst_pc",    dut.pc_q, 32'd0);
    check("post_rst_retired", retired, 32'd0);
    check("post_rst_halted", {31'd0, halted}, 32'd0);
    check("post_rst_r1",    dut.u_rf.mem_q[1], 32'd0);
    check("post_rst_dmem",  {31'd0, dmem_req}, 32'd0);
    repeat (2) @(negedge clk);
    check("post_rst_idle",  {31'd0, imem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
